ps2_key_ctrl: RTL and testbench
===============================

Name: ps2_key_ctrl

Overview:
PS/2 keyboard front end and key-state scheduler for the two-player TankWar input path. Samples raw kclk/kdata in the system clock domain, assembles and checks 11-bit frames, and decodes make/break/extended sequences. Maintains held-key state for both players and resolves each player's direction to a single one-hot command. Feeds the tank movement and fire logic directly.

Parameters:
FILTER_LEN, 4, clk cycles kclk must hold a new level before the filtered clock changes
TIMEOUT_CYC, 100000, clk cycles without a kclk falling edge before a partial frame is aborted
CNT_W, 17, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
kclk  in  1  raw PS/2 clock, asynchronous
kdata  in  1  raw PS/2 data, asynchronous
p1_dir  out  4  player 1 direction, one-hot {right,left,down,up}, 0 = none
p1_fire  out  1  player 1 fire
p2_dir  out  4  player 2 direction, one-hot {right,left,down,up}
p2_fire  out  1  player 2 fire
code_valid  out  1  one-cycle pulse, good frame received
code  out  8  last good scancode; holds its value between frames
frame_err  out  1  one-cycle pulse on bad start, parity, stop, or timeout

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high. On reset all outputs are 0, the held bitmap is cleared, and all FSMs enter IDLE.
- Input conditioning: two-flop synchronizer on kclk and kdata. kclk_f follows the synchronized kclk only after FILTER_LEN consecutive equal samples. A falling edge of kclk_f produces a one-cycle sample strobe that captures the synchronized kdata.
- Frame FSM (IDLE, DATA, PARITY, STOP):
  - IDLE: a strobe with data 0 goes to DATA; data 1 stays in IDLE with no error.
  - DATA: collects 8 bits LSB first, bit counter 0..7, then goes to PARITY.
  - PARITY: requires odd parity over the 8 data bits plus the parity bit.
  - STOP: requires a 1.
  - Good frame: on the clk after the stop strobe, code_valid=1 and code is updated.
  - Any failure: frame_err=1, frame discarded, return to IDLE.
- Timeout: in any state other than IDLE, the timeout counter resets on each strobe. Reaching TIMEOUT_CYC pulses frame_err and returns the FSM to IDLE.
- Prefix decode (flags ext, brk; both cleared by reset and by frame_err):
  - E0 sets ext. F0 sets brk. Both keep their state across frames.
  - Any other code: look up the key index from {ext, code}. Set the held bit on make, clear it on break. Then clear ext and brk.
  - Unknown codes are ignored, and the flags are still cleared.
- Key map:
  - P1: W 1D up, S 1B down, A 1C left, D 23 right, Space 29 fire.
  - P2: E0 75 up, E0 72 down, E0 6B left, E0 74 right, Enter 5A (non-extended) fire.
  - Non-extended 75/72/6B/74 are unmapped.
- Direction resolution (per player):
  - A last register remembers the most recent newly pressed direction.
  - A make for an already-held key (typematic repeat) does not change last.
  - dir = one-hot(last) while last is held.
  - On break of last, fall back to the remaining held direction with fixed priority up>down>left>right; 0 if none are held.
- Output latency: direction and fire outputs update 1 clk after code_valid.
- Fire output: level, equal to the held bit.

Optional Feature:
FIRE_PULSE_EN:
- Defined: p1_fire and p2_fire are single-cycle pulses on a make of a not-held fire key. Typematic repeats and breaks produce no pulse.
- Undefined: fire outputs are levels, as above.

Decomposition:
- Package ps2_key_pkg:
  - scancode localparams (E0, F0, the ten key codes)
  - key index enum (10 entries)
  - frame state enum and direction bit positions
- Sub-module ps2_frame_rx: synchronizer, filter, frame FSM, timeout. Outputs code/code_valid/frame_err.
- The top level keeps prefix decode, held bitmap and direction resolution.

Test Plan:
- Frame 1D (start 0, bits 10111000, parity 1, stop 1) -> code_valid pulse, code=8'h1D; next clk p1_dir=4'b0001.
- 1D make, 23 make -> p1_dir=4'b1000. Then F0 23 -> p1_dir=4'b0001. Then F0 1D -> 4'b0000.
- E0 75 -> p2_dir=4'b0001. E0 F0 75 -> 4'b0000. Plain 75 -> p2_dir unchanged, code_valid still pulses.
- 1D sent with parity bit 0 -> frame_err pulse, no code_valid, p1_dir stays 0. Following good 1D frame decoded normally.
- 5 data bits sent, then idle TIMEOUT_CYC+10 cycles -> single frame_err pulse. Next full 29 frame -> p1_fire=1.
- rst asserted mid-frame while 1D and 29 are held -> all outputs 0 next clk. The partial frame's remaining bits alone produce no code_valid.

Source files
------------

// File: rtl/ps2_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_pkg
// Description : Scancodes, key indices, frame states and direction bit
//               positions shared by the PS/2 key controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_key_pkg;

    localparam logic [7:0] c_SC_E0    = 8'hE0;
    localparam logic [7:0] c_SC_F0    = 8'hF0;
    localparam logic [7:0] c_SC_W     = 8'h1D;
    localparam logic [7:0] c_SC_S     = 8'h1B;
    localparam logic [7:0] c_SC_A     = 8'h1C;
    localparam logic [7:0] c_SC_D     = 8'h23;
    localparam logic [7:0] c_SC_SPACE = 8'h29;
    localparam logic [7:0] c_SC_UP    = 8'h75;
    localparam logic [7:0] c_SC_DOWN  = 8'h72;
    localparam logic [7:0] c_SC_LEFT  = 8'h6B;
    localparam logic [7:0] c_SC_RIGHT = 8'h74;
    localparam logic [7:0] c_SC_ENTER = 8'h5A;

    localparam int c_NUM_KEYS         = 10;
    localparam int c_KEYS_PER_PLAYER  = 5;
    localparam int c_DIR_UP           = 0;
    localparam int c_DIR_DOWN         = 1;
    localparam int c_DIR_LEFT         = 2;
    localparam int c_DIR_RIGHT        = 3;
    localparam int c_FIRE_BIT         = 4;

    // Per-player key order matches the direction bit positions, fire last.
    typedef enum logic [3:0] {
        K_P1_UP    = 4'd0,
        K_P1_DOWN  = 4'd1,
        K_P1_LEFT  = 4'd2,
        K_P1_RIGHT = 4'd3,
        K_P1_FIRE  = 4'd4,
        K_P2_UP    = 4'd5,
        K_P2_DOWN  = 4'd6,
        K_P2_LEFT  = 4'd7,
        K_P2_RIGHT = 4'd8,
        K_P2_FIRE  = 4'd9
    } key_idx_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } frame_state_e;

    typedef struct packed {
        logic     hit;
        key_idx_e idx;
    } key_hit_t;

    function automatic key_hit_t key_lookup(input logic ext, input logic [7:0] sc);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = K_P1_UP;
        case ({ext, sc})
            {1'b0, c_SC_W}:     r.idx = K_P1_UP;
            {1'b0, c_SC_S}:     r.idx = K_P1_DOWN;
            {1'b0, c_SC_A}:     r.idx = K_P1_LEFT;
            {1'b0, c_SC_D}:     r.idx = K_P1_RIGHT;
            {1'b0, c_SC_SPACE}: r.idx = K_P1_FIRE;
            {1'b1, c_SC_UP}:    r.idx = K_P2_UP;
            {1'b1, c_SC_DOWN}:  r.idx = K_P2_DOWN;
            {1'b1, c_SC_LEFT}:  r.idx = K_P2_LEFT;
            {1'b1, c_SC_RIGHT}: r.idx = K_P2_RIGHT;
            {1'b0, c_SC_ENTER}: r.idx = K_P2_FIRE;
            default:            r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_ctrl_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_frame_rx
// Description : PS/2 input synchronizer, kclk glitch filter, 11-bit frame
//               receiver with odd-parity check and inactivity timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_frame_rx
    import ps2_key_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int c_FW = $clog2(FILTER_LEN + 1);

    logic             r_kclk_s1, r_kclk_s2, r_kdata_s1, r_kdata_s2;
    logic             r_kclk_f;
    logic [c_FW-1:0]  r_flt_cnt;
    logic             r_strobe, r_bit;
    frame_state_e     r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_to_cnt;

    // Idle PS/2 lines are high, so reset the conditioning path high to
    // avoid a false falling edge right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kclk_s1  <= 1'b1;
            r_kclk_s2  <= 1'b1;
            r_kdata_s1 <= 1'b1;
            r_kdata_s2 <= 1'b1;
            r_kclk_f   <= 1'b1;
            r_flt_cnt  <= '0;
            r_strobe   <= 1'b0;
            r_bit      <= 1'b1;
        end else begin
            r_kclk_s1  <= kclk;
            r_kclk_s2  <= r_kclk_s1;
            r_kdata_s1 <= kdata;
            r_kdata_s2 <= r_kdata_s1;
            r_strobe   <= 1'b0;
            if (r_kclk_s2 == r_kclk_f) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_FW'(FILTER_LEN - 1)) begin
                r_kclk_f  <= r_kclk_s2;
                r_flt_cnt <= '0;
                r_strobe  <= ~r_kclk_s2;
                r_bit     <= r_kdata_s2;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_to_cnt   <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_strobe && !r_bit) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (r_strobe) begin
                        r_shift   <= {r_bit, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (r_strobe) begin
                        if (^{r_shift, r_bit}) begin
                            r_state <= S_STOP;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                S_STOP: begin
                    if (r_strobe) begin
                        if (r_bit) begin
                            code_valid <= 1'b1;
                            code       <= r_shift;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Timeout only fires between strobes, so it never collides with
            // the state updates above.
            if (r_state == S_IDLE || r_strobe) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                r_to_cnt  <= '0;
                frame_err <= 1'b1;
                r_state   <= S_IDLE;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_ctrl
// Description : TankWar PS/2 front end: prefix decode, held-key bitmap and
//               per-player one-hot direction/fire resolution.
//               Option macro FIRE_PULSE_EN: fire outputs pulse on new press.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_ctrl
    import ps2_key_pkg::*;
#(
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic [3:0] p1_dir,
    output logic       p1_fire,
    output logic [3:0] p2_dir,
    output logic       p2_fire,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       frame_err
);

    logic                  r_ext, r_brk;
    logic [c_NUM_KEYS-1:0] r_held, w_held_nxt;
    key_hit_t              w_lk;
    logic                  w_key_evt, w_press_new;
    logic [3:0]            w_dir_out [2];
    logic                  w_fire_out [2];

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (CNT_W)
    ) u_frame_rx (
        .clk       (clk),
        .rst       (rst),
        .kclk      (kclk),
        .kdata     (kdata),
        .code      (code),
        .code_valid(code_valid),
        .frame_err (frame_err)
    );

    always_comb begin
        w_lk        = key_lookup(r_ext, code);
        w_key_evt   = code_valid && (code != c_SC_E0) && (code != c_SC_F0) && w_lk.hit;
        w_press_new = w_key_evt && !r_brk && !r_held[w_lk.idx];
        w_held_nxt  = r_held;
        if (w_key_evt) w_held_nxt[w_lk.idx] = ~r_brk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext  <= 1'b0;
            r_brk  <= 1'b0;
            r_held <= '0;
        end else begin
            r_held <= w_held_nxt;
            if (frame_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (code_valid) begin
                if (code == c_SC_E0) begin
                    r_ext <= 1'b1;
                end else if (code == c_SC_F0) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_player
        localparam int c_BASE = p * c_KEYS_PER_PLAYER;

        logic [3:0] w_np, w_held_dirs, w_dir_nxt, r_dir;
        logic [1:0] w_last_nxt, r_last;
        logic       w_fire_nxt, r_fire;

        always_comb begin
            for (int k = 0; k < 4; k++) begin
                w_np[k] = w_press_new && (int'(w_lk.idx) == c_BASE + k);
            end
            w_last_nxt = r_last;
            if (w_np[c_DIR_UP])         w_last_nxt = 2'(c_DIR_UP);
            else if (w_np[c_DIR_DOWN])  w_last_nxt = 2'(c_DIR_DOWN);
            else if (w_np[c_DIR_LEFT])  w_last_nxt = 2'(c_DIR_LEFT);
            else if (w_np[c_DIR_RIGHT]) w_last_nxt = 2'(c_DIR_RIGHT);

            // Most recent press wins; otherwise fixed priority up>down>left>right.
            w_held_dirs = w_held_nxt[c_BASE +: 4];
            w_dir_nxt   = 4'b0000;
            if (w_held_dirs[w_last_nxt])         w_dir_nxt = 4'b0001 << w_last_nxt;
            else if (w_held_dirs[c_DIR_UP])      w_dir_nxt = 4'b0001;
            else if (w_held_dirs[c_DIR_DOWN])    w_dir_nxt = 4'b0010;
            else if (w_held_dirs[c_DIR_LEFT])    w_dir_nxt = 4'b0100;
            else if (w_held_dirs[c_DIR_RIGHT])   w_dir_nxt = 4'b1000;

`ifdef FIRE_PULSE_EN
            w_fire_nxt = w_press_new && (int'(w_lk.idx) == c_BASE + c_FIRE_BIT);
`else
            w_fire_nxt = w_held_nxt[c_BASE + c_FIRE_BIT];
`endif
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_last <= '0;
                r_dir  <= '0;
                r_fire <= 1'b0;
            end else begin
                r_last <= w_last_nxt;
                r_dir  <= w_dir_nxt;
                r_fire <= w_fire_nxt;
            end
        end

        assign w_dir_out[p]  = r_dir;
        assign w_fire_out[p] = r_fire;
    end

    assign p1_dir  = w_dir_out[0];
    assign p1_fire = w_fire_out[0];
    assign p2_dir  = w_dir_out[1];
    assign p2_fire = w_fire_out[1];

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_ctrl
// Description : Scoreboard bench for ps2_key_ctrl with directed PS/2 frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_ctrl;

    localparam int c_TO = 300;
`ifdef FIRE_PULSE_EN
    localparam logic c_FIRE_LVL = 1'b0;
`else
    localparam logic c_FIRE_LVL = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kclk = 1'b1;
    logic       kdata = 1'b1;
    logic [3:0] p1_dir, p2_dir;
    logic       p1_fire, p2_fire, code_valid, frame_err;
    logic [7:0] code;

    always #5 clk = ~clk;

    ps2_key_ctrl #(
        .FILTER_LEN (4),
        .TIMEOUT_CYC(c_TO),
        .CNT_W      (17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kclk      (kclk),
        .kdata     (kdata),
        .p1_dir    (p1_dir),
        .p1_fire   (p1_fire),
        .p2_dir    (p2_dir),
        .p2_fire   (p2_fire),
        .code_valid(code_valid),
        .code      (code),
        .frame_err (frame_err)
    );

    typedef struct {
        logic       err;
        logic [7:0] code;
        logic [3:0] p1d;
        logic       p1f;
        logic [3:0] p2d;
        logic       p2f;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input logic err, input logic [7:0] c, input logic [3:0] p1d,
                        input logic p1f, input logic [3:0] p2d, input logic p2f);
        exp_t e;
        e.err = err; e.code = c; e.p1d = p1d; e.p1f = p1f; e.p2d = p2d; e.p2f = p2f;
        q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) kdata = b;
        repeat (5) @(negedge clk);
        kclk = 1'b0;
        repeat (10) @(negedge clk);
        kclk = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic bad_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(c[i]);
        send_bit((~^c) ^ bad_par);
        send_bit(1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic key(input logic [7:0] c, input logic [3:0] p1d, input logic p1f,
                       input logic [3:0] p2d, input logic p2f);
        push(1'b0, c, p1d, p1f, p2d, p2f);
        send_frame(c, 1'b0);
    endtask

    // Monitor: every output event pops one expectation; dir/fire checked a clk later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (code_valid || frame_err)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event valid=%0b err=%0b code=%0h", code_valid, frame_err, code);
                end else begin
                    e = q.pop_front();
                    chk("event_is_err", {7'd0, frame_err}, {7'd0, e.err});
                    if (!e.err) chk("code", code, e.code);
                    @(negedge clk);
                    chk("pulse_len", {6'd0, code_valid, frame_err}, 8'd0);
                    chk("p1_dir", {4'd0, p1_dir}, {4'd0, e.p1d});
                    chk("p1_fire", {7'd0, p1_fire}, {7'd0, e.p1f});
                    chk("p2_dir", {4'd0, p2_dir}, {4'd0, e.p2d});
                    chk("p2_fire", {7'd0, p2_fire}, {7'd0, e.p2f});
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_p1_dir"}, {4'd0, p1_dir}, 8'd0);
        chk({tag, "_p2_dir"}, {4'd0, p2_dir}, 8'd0);
        chk({tag, "_fires"}, {6'd0, p1_fire, p2_fire}, 8'd0);
        chk({tag, "_code"}, code, 8'd0);
        chk({tag, "_pulses"}, {6'd0, code_valid, frame_err}, 8'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic make/break and last-pressed priority
        key(8'h1D, 4'b0001, 0, 4'b0000, 0);
        key(8'h23, 4'b1000, 0, 4'b0000, 0);
        key(8'hF0, 4'b1000, 0, 4'b0000, 0);
        key(8'h23, 4'b0001, 0, 4'b0000, 0);
        key(8'hF0, 4'b0001, 0, 4'b0000, 0);
        key(8'h1D, 4'b0000, 0, 4'b0000, 0);

        // Typematic repeat of W must not steal "last" from D
        key(8'h1D, 4'b0001, 0, 4'b0000, 0);
        key(8'h23, 4'b1000, 0, 4'b0000, 0);
        key(8'h1D, 4'b1000, 0, 4'b0000, 0);
        key(8'hF0, 4'b1000, 0, 4'b0000, 0);
        key(8'h23, 4'b0001, 0, 4'b0000, 0);
        key(8'hF0, 4'b0001, 0, 4'b0000, 0);
        key(8'h1D, 4'b0000, 0, 4'b0000, 0);

        // Fallback priority down over left
        key(8'h1B, 4'b0010, 0, 4'b0000, 0);
        key(8'h1C, 4'b0100, 0, 4'b0000, 0);
        key(8'h23, 4'b1000, 0, 4'b0000, 0);
        key(8'hF0, 4'b1000, 0, 4'b0000, 0);
        key(8'h23, 4'b0010, 0, 4'b0000, 0);
        key(8'hF0, 4'b0010, 0, 4'b0000, 0);
        key(8'h1B, 4'b0100, 0, 4'b0000, 0);
        key(8'hF0, 4'b0100, 0, 4'b0000, 0);
        key(8'h1C, 4'b0000, 0, 4'b0000, 0);

        // Player 2 extended arrows, unmapped plain 75, Enter fire
        key(8'hE0, 4'b0000, 0, 4'b0000, 0);
        key(8'h75, 4'b0000, 0, 4'b0001, 0);
        key(8'hE0, 4'b0000, 0, 4'b0001, 0);
        key(8'hF0, 4'b0000, 0, 4'b0001, 0);
        key(8'h75, 4'b0000, 0, 4'b0000, 0);
        key(8'h75, 4'b0000, 0, 4'b0000, 0);
        key(8'h5A, 4'b0000, 0, 4'b0000, 1);
        key(8'hF0, 4'b0000, 0, 4'b0000, c_FIRE_LVL);
        key(8'h5A, 4'b0000, 0, 4'b0000, 0);

        // Parity error, then a good frame
        push(1'b1, 8'h00, 4'b0000, 0, 4'b0000, 0);
        send_frame(8'h1D, 1'b1);
        key(8'h1D, 4'b0001, 0, 4'b0000, 0);
        key(8'hF0, 4'b0001, 0, 4'b0000, 0);
        key(8'h1D, 4'b0000, 0, 4'b0000, 0);

        // Timeout on a partial frame, then Space
        push(1'b1, 8'h00, 4'b0000, 0, 4'b0000, 0);
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        repeat (c_TO + 10) @(negedge clk);
        key(8'h29, 4'b0000, 1, 4'b0000, 0);
        key(8'h1D, 4'b0001, c_FIRE_LVL, 4'b0000, 0);

        // Reset mid-frame while W and Space are held
        send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        push(1'b1, 8'h00, 4'b0000, 0, 4'b0000, 0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1);
        repeat (c_TO + 10) @(negedge clk);
        key(8'h23, 4'b1000, 0, 4'b0000, 0);

        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0 pending", q.size());
        end
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
